slave_out_port: RTL and testbench
=================================

SLAVE_OUT_PORT -- requirements
Module: slave_out_port

Interface
REQ-001 Parameter DATA_LEN, default 8: bits per serial word; the block SHALL support DATA_LEN >= 2.
REQ-002 Parameter BURST_LEN, default 12: width of the burst count field.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 read_start  input  1  one-cycle pulse from slave command decoder: a read request was accepted.
REQ-006 burst_num  input  BURST_LEN  words in the burst minus one, sampled with read_start.
REQ-007 read_en  output  1  read strobe to slave memory, one cycle per word.
REQ-008 word_idx  output  BURST_LEN  word offset within the burst for the current read_en.
REQ-009 datain  input  DATA_LEN  memory read data, valid the cycle after read_en.
REQ-010 tx_data  output  1  serial data line to master, LSB first.
REQ-011 slave_valid  output  1  word ready to send, waiting for handshake.
REQ-012 master_ready  input  1  master can accept a word.
REQ-013 tx_done  output  1  one-cycle pulse after the last bit of the burst.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH, LOAD, WAIT_HANDSHAKE and SEND, plus internal registers shift_reg[DATA_LEN], bit_cnt, word_cnt[BURST_LEN] and burst_reg[BURST_LEN].
REQ-016 IDLE: if read_start=1, latch burst_num->burst_reg, word_cnt<=0, go FETCH; otherwise remain in IDLE with slave_valid=0, read_en=0.
REQ-017 FETCH: read_en=1 and word_idx=word_cnt for exactly this cycle, then go LOAD.
REQ-018 LOAD: shift_reg<=datain, then go WAIT_HANDSHAKE (memory latency of one cycle is fixed).
REQ-019 WAIT_HANDSHAKE: slave_valid=1 and tx_data=shift_reg[0]; on an edge where master_ready=1, shift_reg shifts right by one, bit_cnt<=1, slave_valid<=0, go SEND; otherwise hold.
REQ-020 The handshake cycle SHALL carry bit 0; bit k SHALL be on tx_data exactly k cycles after the handshake edge, for k = 1 .. DATA_LEN-1, with no gaps.
REQ-021 SEND: each cycle shift right and increment bit_cnt; master_ready is ignored in SEND.
REQ-022 SEND with bit_cnt = DATA_LEN-1: if word_cnt = burst_reg, pulse tx_done for one cycle and go IDLE; otherwise word_cnt<=word_cnt+1 and go FETCH.
REQ-023 Words per burst SHALL be burst_reg+1; burst_num=0 gives one word, and all-ones gives 2^BURST_LEN words with no counter overflow (equality compare before increment).
REQ-024 read_start outside IDLE SHALL be ignored; burst_num changes after latching SHALL have no effect.
REQ-025 tx_data SHALL equal shift_reg[0] at all times; its value outside WAIT_HANDSHAKE/SEND is don't-care but deterministic.
REQ-026 tx_done SHALL NOT be asserted in the same cycle as slave_valid or read_en.
REQ-027 Minimum inter-word gap: last bit, FETCH, LOAD, then slave_valid high; that is 2 idle line cycles.
REQ-028 Undefined state encodings SHALL return to IDLE on the next edge with outputs at reset values.

Reset
REQ-029 When reset_n=0, asynchronously: state=IDLE, read_en=0, word_idx=0, slave_valid=0, tx_done=0, busy=0, shift_reg=0 (tx_data=0), bit_cnt=0, word_cnt=0, burst_reg=0.
REQ-030 Reset mid-burst SHALL abort the burst without a tx_done pulse; the first edge after release SHALL be IDLE behaviour.

Verification
REQ-031 burst_num=0, datain=8'hA5, master_ready held 1 -> read_en for 1 cycle, slave_valid high 1 cycle, tx_data sequence 1,0,1,0,0,1,0,1, tx_done pulse the cycle after bit 7.
REQ-032 burst_num=2, datain 8'h01,8'h80,8'hFF -> word_idx 0,1,2 on three read_en pulses, 24 bits received exactly, one tx_done only after the third word.
REQ-033 master_ready=0 for 5 cycles in WAIT_HANDSHAKE -> slave_valid held 5+ cycles, tx_data stable at bit 0, no shift until ready=1.
REQ-034 read_start pulsed during SEND -> ignored; burst length unchanged; busy stays 1.
REQ-035 reset_n low at bit 3 of word 1 of a 4-word burst -> all outputs 0 immediately, no tx_done; new read_start after release runs a clean burst.
REQ-036 Loopback with master receiver (DATA_LEN=8, burst_num=3) -> master collects 4 words identical to memory contents, and its receive-done pulse matches tx_done timing.

Source files
------------

// File: rtl/slave_out_port.sv
// Slave-side serial read port: fetches a burst of words from slave memory and
// shifts each one out LSB first after a valid/ready handshake with the master.
module slave_out_port #(
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 read_start,
    input  logic [BURST_LEN-1:0] burst_num,
    output logic                 read_en,
    output logic [BURST_LEN-1:0] word_idx,
    input  logic [DATA_LEN-1:0]  datain,
    output logic                 tx_data,
    output logic                 slave_valid,
    input  logic                 master_ready,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    state_t               state_r;
    logic [DATA_LEN-1:0]  shift_reg_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [BURST_LEN-1:0] word_cnt_r;
    logic [BURST_LEN-1:0] burst_reg_r;
    logic [BURST_LEN-1:0] word_idx_r;
    logic                 read_en_r;
    logic                 slave_valid_r;
    logic                 tx_done_r;
    logic                 busy_r;

    assign read_en     = read_en_r;
    assign word_idx    = word_idx_r;
    assign tx_data     = shift_reg_r[0];
    assign slave_valid = slave_valid_r;
    assign tx_done     = tx_done_r;
    assign busy        = busy_r;

    // Burst sequencer; every output is set on the edge that enters its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            shift_reg_r   <= {DATA_LEN{1'b0}};
            bit_cnt_r     <= {CNT_W{1'b0}};
            word_cnt_r    <= {BURST_LEN{1'b0}};
            burst_reg_r   <= {BURST_LEN{1'b0}};
            word_idx_r    <= {BURST_LEN{1'b0}};
            read_en_r     <= 1'b0;
            slave_valid_r <= 1'b0;
            tx_done_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            read_en_r <= 1'b0;
            tx_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    slave_valid_r <= 1'b0;
                    if (read_start) begin
                        burst_reg_r <= burst_num;
                        word_cnt_r  <= {BURST_LEN{1'b0}};
                        word_idx_r  <= {BURST_LEN{1'b0}};
                        read_en_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                // Memory returns data one cycle after the strobe, i.e. during LOAD.
                ST_LOAD: begin
                    shift_reg_r   <= datain;
                    slave_valid_r <= 1'b1;
                    state_r       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (master_ready) begin
                        shift_reg_r   <= {1'b0, shift_reg_r[DATA_LEN-1:1]};
                        bit_cnt_r     <= CNT_W'(1);
                        slave_valid_r <= 1'b0;
                        state_r       <= ST_SEND;
                    end else begin
                        slave_valid_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    shift_reg_r <= {1'b0, shift_reg_r[DATA_LEN-1:1]};
                    if (bit_cnt_r == CNT_W'(DATA_LEN - 1)) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        // Compare before increment so an all-ones burst never wraps.
                        if (word_cnt_r == burst_reg_r) begin
                            tx_done_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            word_cnt_r <= word_cnt_r + BURST_LEN'(1);
                            word_idx_r <= word_cnt_r + BURST_LEN'(1);
                            read_en_r  <= 1'b1;
                            state_r    <= ST_FETCH;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    shift_reg_r   <= {DATA_LEN{1'b0}};
                    bit_cnt_r     <= {CNT_W{1'b0}};
                    word_cnt_r    <= {BURST_LEN{1'b0}};
                    burst_reg_r   <= {BURST_LEN{1'b0}};
                    word_idx_r    <= {BURST_LEN{1'b0}};
                    slave_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_out_port.sv
// Randomized bench for slave_out_port: a memory responder and a serial master
// receiver rebuild each burst and compare it with the words stored in memory.
module tb_slave_out_port;

    localparam int DL = 8;
    localparam int BL = 4;

    logic          clk;
    logic          reset_n;
    logic          read_start;
    logic [BL-1:0] burst_num;
    logic          read_en;
    logic [BL-1:0] word_idx;
    logic [DL-1:0] datain;
    logic          tx_data;
    logic          slave_valid;
    logic          master_ready;
    logic          tx_done;
    logic          busy;

    logic [DL-1:0] mem [0:15];
    int            vec_cnt;
    int            err_cnt;

    slave_out_port #(.DATA_LEN(DL), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .read_start   (read_start),
        .burst_num    (burst_num),
        .read_en      (read_en),
        .word_idx     (word_idx),
        .datain       (datain),
        .tx_data      (tx_data),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .tx_done      (tx_done),
        .busy         (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_en"}, 32'(read_en), 32'd0);
        chk({tag, "_word_idx"}, 32'(word_idx), 32'd0);
        chk({tag, "_valid"}, 32'(slave_valid), 32'd0);
        chk({tag, "_done"}, 32'(tx_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    endtask

    // One burst of nm1+1 words; cycles are sampled and driven on the falling edge.
    task automatic run_burst(input int nm1, input int unsigned ready_pct, input bit stall5,
                             input bit poke, input bit abort, input bit keep_mem);
        int            rd_k, wr_k, bit_pos, stall_left;
        bit            in_word, prev_rd, done_exp, finished, aborted;
        logic [BL-1:0] prev_idx;
        logic [DL-1:0] word_acc;
        if (!keep_mem)
            for (int i = 0; i <= nm1; i++) mem[i] = DL'($urandom);
        @(negedge clk);
        read_start = 1'b1;
        burst_num  = BL'(nm1);
        rd_k = 0; wr_k = 0; bit_pos = 0; in_word = 1'b0; prev_rd = 1'b0;
        done_exp = 1'b0; finished = 1'b0; aborted = 1'b0;
        prev_idx = '0; word_acc = '0;
        stall_left = stall5 ? 5 : 0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            read_start = 1'b0;
            burst_num  = BL'($urandom);
            datain     = prev_rd ? mem[prev_idx] : DL'($urandom);
            prev_rd    = read_en;
            prev_idx   = word_idx;
            if (read_en) begin
                chk("word_idx", 32'(word_idx), 32'(rd_k));
                rd_k++;
            end
            chk("tx_done", 32'(tx_done), 32'(done_exp));
            if (done_exp) begin
                chk("busy_end", 32'(busy), 32'd0);
                chk("valid_at_done", 32'(slave_valid), 32'd0);
                chk("rd_at_done", 32'(read_en), 32'd0);
                finished = 1'b1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
            end
            if (!finished) begin
                if (in_word) begin
                    chk("valid_in_send", 32'(slave_valid), 32'd0);
                    word_acc[bit_pos] = tx_data;
                    bit_pos++;
                    master_ready = 1'($urandom);
                    if (poke && wr_k == 0 && bit_pos == 4) read_start = 1'b1;
                    if (bit_pos == DL) begin
                        chk("rx_word", 32'(word_acc), 32'(mem[wr_k]));
                        in_word = 1'b0;
                        if (wr_k == nm1) done_exp = 1'b1;
                        wr_k++;
                    end
                    if (abort && wr_k == 1 && in_word && bit_pos == 4) begin
                        reset_n = 1'b0;
                        #1;
                        chk_reset_outputs("abort");
                        aborted  = 1'b1;
                        finished = 1'b1;
                    end
                end else if (slave_valid) begin
                    if (stall_left > 0) begin
                        master_ready = 1'b0;
                        stall_left--;
                    end else begin
                        master_ready = ($urandom_range(99) < ready_pct);
                    end
                    chk("tx_bit0", 32'(tx_data), 32'(mem[wr_k][0]));
                    if (master_ready) begin
                        word_acc    = '0;
                        word_acc[0] = tx_data;
                        bit_pos     = 1;
                        in_word     = 1'b1;
                    end
                end else begin
                    master_ready = 1'($urandom);
                end
            end
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                chk("abort_no_done", 32'(tx_done), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
            end
            reset_n = 1'b1;
            @(negedge clk);
            chk("post_release_idle", 32'(busy), 32'd0);
        end else begin
            chk("rd_count", 32'(rd_k), 32'(nm1 + 1));
            chk("word_count", 32'(wr_k), 32'(nm1 + 1));
        end
    endtask

    initial begin
        vec_cnt = 0; err_cnt = 0;
        clk = 1'b0; reset_n = 1'b0; read_start = 1'b0; burst_num = '0;
        datain = '0; master_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        mem[0] = 8'hA5;
        run_burst(0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
        run_burst(2, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        run_burst(1, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        run_burst(2, 70, 1'b0, 1'b1, 1'b0, 1'b0);
        run_burst(15, 60, 1'b0, 1'b0, 1'b0, 1'b0);
        run_burst(3, 100, 1'b0, 1'b0, 1'b1, 1'b0);
        run_burst(3, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 12; r++)
            run_burst(int'($urandom_range(15)), $urandom_range(100, 20), 1'b0,
                      1'($urandom), 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
